// File: rtl/tenthirty_ctrl.sv
// Ten-and-a-half game controller: draws cards from the LUT, scores player/dealer, decides rounds.
// Latency: pip one cycle after the button; score updates the cycle after number is valid (LUT_LAT after pip).
// Backpressure: none; buttons arriving while a draw is in flight or in an ignoring state are dropped.
module tenthirty_ctrl #(
    parameter int LUT_LAT   = 1,
    parameter int MAX_CARDS = 5,
    parameter int ROUNDS    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_m,
    input  logic       btn_r,
    input  logic [3:0] number,
    output logic       pip,
    output logic [5:0] player_pts,
    output logic [5:0] dealer_pts,
    output logic [3:0] last_card,
    output logic       last_owner,
    output logic [1:0] round_idx,
    output logic [2:0] led
);

    typedef enum logic [3:0] {
        IDLE, P_REQ, P_WAIT, P_HOLD, D_TURN, D_REQ, D_WAIT, D_HOLD, RESULT, DONE
    } state_t;

    localparam logic [1:0] LAT_C  = 2'(LUT_LAT);
    localparam logic [2:0] MAX_C  = 3'(MAX_CARDS);
    localparam logic [1:0] LAST_R = 2'(ROUNDS - 1);

    state_t     r_state;
    state_t     w_next;
    logic       w_pip;
    logic       w_take;
    logic       w_new_round;
    logic [5:0] w_val;
    logic       w_p_bust;
    logic       w_d_bust;
    logic       w_player_wins;

    logic [1:0] r_wait_cnt;
    logic [2:0] r_p_cnt;
    logic [2:0] r_d_cnt;
    logic [5:0] r_player_pts;
    logic [5:0] r_dealer_pts;
    logic [3:0] r_last_card;
    logic       r_last_owner;
    logic [1:0] r_round;
    logic [2:0] r_led;

    // Card value in half-points: pip cards count double, faces and out-of-range codes count one.
    always_comb begin
        w_val = 6'd1;
        if (number >= 4'd1 && number <= 4'd10) begin
            w_val = {1'b0, number, 1'b0};
        end
    end

    assign w_p_bust      = r_player_pts > 6'd21;
    assign w_d_bust      = r_dealer_pts > 6'd21;
    // A player bust always loses; ties go to the dealer.
    assign w_player_wins = !w_p_bust && (w_d_bust || (r_player_pts > r_dealer_pts));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic with draw request, card capture and new-round strobes.
    always_comb begin
        w_next      = r_state;
        w_pip       = 1'b0;
        w_take      = 1'b0;
        w_new_round = 1'b0;
        case (r_state)
            IDLE:   if (btn_m) w_next = P_REQ;
            P_REQ: begin
                w_pip  = 1'b1;
                w_next = P_WAIT;
            end
            P_WAIT: if (r_wait_cnt == LAT_C) begin
                w_take = 1'b1;
                w_next = P_HOLD;
            end
            P_HOLD: begin
                if (w_p_bust)              w_next = RESULT;
                else if (r_p_cnt == MAX_C) w_next = D_TURN;
                else if (btn_m)            w_next = P_REQ;
                else if (btn_r)            w_next = D_TURN;
            end
            D_TURN: if (btn_m) w_next = D_REQ;
            D_REQ: begin
                w_pip  = 1'b1;
                w_next = D_WAIT;
            end
            D_WAIT: if (r_wait_cnt == LAT_C) begin
                w_take = 1'b1;
                w_next = D_HOLD;
            end
            D_HOLD: begin
                if (w_d_bust)              w_next = RESULT;
                else if (r_d_cnt == MAX_C) w_next = RESULT;
                else if (btn_m)            w_next = D_REQ;
                else if (btn_r)            w_next = RESULT;
            end
            RESULT: if (btn_m) begin
                if (r_round == LAST_R) begin
                    w_next = DONE;
                end else begin
                    w_next      = P_REQ;
                    w_new_round = 1'b1;
                end
            end
            DONE:    w_next = DONE;
            default: w_next = IDLE;
        endcase
    end

    // Datapath: LUT wait counter, score accumulation, round bookkeeping and LEDs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt   <= 2'd0;
            r_p_cnt      <= 3'd0;
            r_d_cnt      <= 3'd0;
            r_player_pts <= 6'd0;
            r_dealer_pts <= 6'd0;
            r_last_card  <= 4'd0;
            r_last_owner <= 1'b0;
            r_round      <= 2'd0;
            r_led        <= 3'd0;
        end else begin
            // The pip cycle counts as the first cycle of LUT latency.
            if (r_state == P_REQ || r_state == D_REQ) begin
                r_wait_cnt <= 2'd1;
            end else if ((r_state == P_WAIT || r_state == D_WAIT) && !w_take) begin
                r_wait_cnt <= r_wait_cnt + 2'd1;
            end

            if (w_take) begin
                r_last_card <= number;
                if (r_state == P_WAIT) begin
                    r_player_pts <= r_player_pts + w_val;
                    r_p_cnt      <= r_p_cnt + 3'd1;
                    r_last_owner <= 1'b0;
                end else begin
                    r_dealer_pts <= r_dealer_pts + w_val;
                    r_d_cnt      <= r_d_cnt + 3'd1;
                    r_last_owner <= 1'b1;
                end
            end

            // Winner latched on entry to RESULT, from the final hold-state scores.
            if (r_state != RESULT && w_next == RESULT) begin
                r_led[1:0] <= {w_player_wins, !w_player_wins};
            end

            if (w_new_round) begin
                r_player_pts <= 6'd0;
                r_dealer_pts <= 6'd0;
                r_p_cnt      <= 3'd0;
                r_d_cnt      <= 3'd0;
                r_led[1:0]   <= 2'b00;
                r_round      <= r_round + 2'd1;
            end

            if (r_state == RESULT && w_next == DONE) begin
                r_led[2] <= 1'b1;
            end
        end
    end

    assign pip        = w_pip;
    assign player_pts = r_player_pts;
    assign dealer_pts = r_dealer_pts;
    assign last_card  = r_last_card;
    assign last_owner = r_last_owner;
    assign round_idx  = r_round;
    assign led        = r_led;

endmodule

// File: tb/tb_tenthirty_ctrl.sv
// Directed bench for tenthirty_ctrl with a three-cycle LUT.
// Latency: number is presented exactly LAT cycles after each observed pip, garbage otherwise.
// Backpressure: none; button pulses are one cycle wide, some deliberately land in wait states.
module tb_tenthirty_ctrl;

    localparam int LAT = 3;

    logic       clk;
    logic       rst;
    logic       btn_m;
    logic       btn_r;
    logic [3:0] number;
    logic       pip;
    logic [5:0] player_pts;
    logic [5:0] dealer_pts;
    logic [3:0] last_card;
    logic       last_owner;
    logic [1:0] round_idx;
    logic [2:0] led;

    int n_tests = 0;
    int n_fail  = 0;

    tenthirty_ctrl #(.LUT_LAT(LAT), .MAX_CARDS(5), .ROUNDS(4)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .btn_m      (btn_m),
        .btn_r      (btn_r),
        .number     (number),
        .pip        (pip),
        .player_pts (player_pts),
        .dealer_pts (dealer_pts),
        .last_card  (last_card),
        .last_owner (last_owner),
        .round_idx  (round_idx),
        .led        (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs set afterwards are sampled at the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press_m();
        btn_m = 1'b1;
        tick();
        btn_m = 1'b0;
    endtask

    task automatic stand();
        btn_r = 1'b1;
        tick();
        btn_r = 1'b0;
    endtask

    // Called in the pip cycle; returns in the hold cycle after the card is scored.
    // When noisy, btn_m is held high throughout the request/wait window.
    task automatic take(input logic [3:0] card, input bit noisy);
        check("pip_on", pip, 1);
        btn_m = noisy;
        for (int i = 0; i < LAT; i++) begin
            tick();
            check("pip_off_wait", pip, 0);
        end
        number = card;
        tick();
        number = 4'd9;
        btn_m  = 1'b0;
    endtask

    task automatic hit(input logic [3:0] card);
        press_m();
        take(card, 1'b0);
    endtask

    initial begin
        rst    = 1'b1;
        btn_m  = 1'b0;
        btn_r  = 1'b0;
        number = 4'd9;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rst_led", led, 0);
        check("rst_ppts", player_pts, 0);

        // Reset in the middle of a draw, then a late LUT response.
        press_m();
        check("first_pip", pip, 1);
        tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst2_pip", pip, 0);
        check("rst2_ppts", player_pts, 0);
        check("rst2_dpts", dealer_pts, 0);
        check("rst2_card", last_card, 0);
        check("rst2_owner", last_owner, 0);
        check("rst2_round", round_idx, 0);
        check("rst2_led", led, 0);
        number = 4'd10;
        tick();
        tick();
        number = 4'd9;
        check("late_num_ppts", player_pts, 0);
        check("late_num_pip", pip, 0);

        // Round 0: 10 then A -> player bust.
        hit(4'd10);
        check("r0_p20", player_pts, 20);
        check("r0_card", last_card, 10);
        check("r0_owner", last_owner, 0);
        hit(4'd1);
        check("r0_p22", player_pts, 22);
        tick();
        check("r0_led", led, 3'b001);
        check("r0_dpts", dealer_pts, 0);
        btn_r = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("r0_no_pip", pip, 0);
        end
        btn_r = 1'b0;
        check("r0_led_hold", led, 3'b001);

        // Round 1: player 7,K stand; dealer 6,Q stand -> player wins.
        press_m();
        check("r1_round", round_idx, 1);
        check("r1_clr_p", player_pts, 0);
        check("r1_clr_led", led, 0);
        take(4'd7, 1'b0);
        check("r1_p14", player_pts, 14);
        hit(4'd13);
        check("r1_p15", player_pts, 15);
        stand();
        check("r1_dturn_pip", pip, 0);
        hit(4'd6);
        check("r1_d12", dealer_pts, 12);
        check("r1_owner", last_owner, 1);
        check("r1_card", last_card, 6);
        hit(4'd12);
        check("r1_d13", dealer_pts, 13);
        stand();
        check("r1_led", led, 3'b010);
        check("r1_p_keep", player_pts, 15);
        check("r1_d_keep", dealer_pts, 13);

        // Round 2: 8 vs 8 -> tie goes to dealer.
        press_m();
        check("r2_round", round_idx, 2);
        take(4'd8, 1'b0);
        stand();
        hit(4'd8);
        stand();
        check("r2_p16", player_pts, 16);
        check("r2_d16", dealer_pts, 16);
        check("r2_led", led, 3'b001);

        // Round 3: five face cards, simultaneous buttons, dropped presses, dealer bust.
        press_m();
        check("r3_round", round_idx, 3);
        take(4'd11, 1'b0);
        btn_m = 1'b1;
        btn_r = 1'b1;
        tick();
        btn_m = 1'b0;
        btn_r = 1'b0;
        take(4'd12, 1'b1);
        check("r3_p2", player_pts, 2);
        tick();
        check("r3_dropped", pip, 0);
        check("r3_p2_keep", player_pts, 2);
        hit(4'd13);
        hit(4'd11);
        hit(4'd12);
        check("r3_p5", player_pts, 5);
        tick();
        tick();
        stand();
        check("r3_dturn_btnr", pip, 0);
        tick();
        check("r3_dturn_idle", pip, 0);
        hit(4'd5);
        check("r3_d10", dealer_pts, 10);
        check("r3_p5_keep", player_pts, 5);
        hit(4'd10);
        check("r3_d30", dealer_pts, 30);
        tick();
        check("r3_led", led, 3'b010);

        // Game over after the fourth result.
        press_m();
        check("done_led", led, 3'b110);
        btn_m = 1'b1;
        btn_r = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("done_no_pip", pip, 0);
        end
        btn_m = 1'b0;
        btn_r = 1'b0;
        check("done_led_hold", led, 3'b110);
        check("done_p_frz", player_pts, 5);
        check("done_d_frz", dealer_pts, 30);
        check("done_round", round_idx, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tenthirty_ctrl.md
Name: tenthirty_ctrl

Overview:
- Game controller for the ten-and-a-half card game: sequences card draws from the LUT card source (pip request, number response), and accumulates player and dealer scores.
- Decides each round's winner, counts rounds and drives the result LEDs.
- Sits between the debounced button pulses and the LUT; exposes scores, last card and round number to the seven-segment formatting logic.

Parameters:
- LUT_LAT, 1, cycles from pip pulse to number being valid (1..3)
- MAX_CARDS, 5, cards per hand before forced stand
- ROUNDS, 4, rounds per game before DONE

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- btn_m  in  1  one-cycle pulse: deal / hit / next round
- btn_r  in  1  one-cycle pulse: stand
- number  in  4  card value from LUT (1=A .. 13=K), valid LUT_LAT cycles after pip
- pip  out  1  one-cycle draw request to LUT
- player_pts  out  6  player score in half-points
- dealer_pts  out  6  dealer score in half-points
- last_card  out  4  most recently drawn number
- last_owner  out  1  0=player, 1=dealer drew last_card
- round_idx  out  2  current round, 0..ROUNDS-1
- led  out  3  led[0] dealer win, led[1] player win, led[2] game done

Behaviour:
- Reset: only clk and rst are used; no internal clock division (button pulses arrive in the clk domain). rst is sampled on the clk edge and overrides all other inputs that cycle, including mid-draw. State=IDLE; pip, player_pts, dealer_pts, last_card, last_owner, round_idx and led all 0; per-hand card counters 0. A pending LUT response after reset is ignored.
- Scoring: number 1..10 adds 2*number half-points; any other value (11..13, plus out-of-range 0, 14, 15) adds 1. Bust means score > 21 (10.5). Scores are 6-bit and cannot overflow, because the maximum is 21+20=41.
- States: IDLE, P_REQ, P_WAIT, P_HOLD, D_TURN, D_REQ, D_WAIT, D_HOLD, RESULT, DONE.
- IDLE: btn_m -> P_REQ.
- P_REQ: pip=1 for exactly one cycle -> P_WAIT.
- P_WAIT: count LUT_LAT cycles from the pip cycle, then on the cycle number is valid:
  - player_pts += value; last_card=number; last_owner=0; player card count +1.
  - Next state is P_HOLD.
- P_HOLD, evaluated in priority order:
  - Player bust -> RESULT with dealer win; the dealer does not draw.
  - Card count = MAX_CARDS -> D_TURN.
  - btn_m -> P_REQ.
  - btn_r -> D_TURN.
- D_TURN: waits for btn_m -> D_REQ. The dealer always takes at least one card, so btn_r is ignored here.
- D_REQ, D_WAIT and D_HOLD mirror the player states, using dealer_pts, last_owner=1 and the dealer card count:
  - Dealer bust -> RESULT.
  - Card count = MAX_CARDS, or btn_r -> RESULT.
  - btn_m -> D_REQ.
- RESULT, winner decided on entry:
  - Player bust -> dealer wins.
  - Else dealer bust -> player wins.
  - Else higher score wins; a tie goes to the dealer.
  - The winning LED (led[0] or led[1]) is set and held, exactly one of the two.
  - Scores stay visible during RESULT.
  - On btn_m with round_idx = ROUNDS-1 -> DONE.
  - On btn_m otherwise: clear scores, card counts and led[1:0]; round_idx +1; go to P_REQ (the first card of the next round is dealt immediately).
- DONE: led[2]=1; led[1:0] keep the last round's result; scores frozen; all buttons ignored until rst.
- Button rules:
  - btn_m and btn_r in the same cycle: btn_m wins.
  - Buttons in any REQ/WAIT state are dropped, not queued.
  - btn_r is ignored in IDLE, D_TURN, RESULT and DONE.
- pip never asserts on two consecutive cycles, and never asserts again before the previous card has been taken.

Test Plan:
- rst high for 2 cycles mid-P_WAIT -> the cycle after the rst edge: all outputs 0, state IDLE; a late number from the LUT does not change the scores.
- Player draws 10, then btn_m; LUT returns 1 -> player_pts=20, then 22 -> bust. led=3'b001 one cycle after scoring; dealer_pts stays 0 and pip is not asserted again.
- Player draws 7, K, stand; dealer draws 6, btn_m, Q, stand -> player_pts=15, dealer_pts=13, led=3'b010.
- Equal scores: player 8 stand, dealer 8 stand -> both scores 16, led=3'b001 (tie goes to the dealer).
- Player draws five face cards (J,Q,K,J,Q) -> player_pts=5 and the controller auto-enters D_TURN with no btn_r; btn_r in D_TURN is ignored.
- Four complete rounds with btn_m after each RESULT -> round_idx counts 0..3; after the fourth result plus btn_m, led[2]=1. Further btn_m/btn_r produce no pip.
- btn_m and btn_r asserted in the same cycle in P_HOLD -> a pip follows (hit), not a stand. With LUT_LAT=3, pip-to-score latency is 3 cycles and button pulses during the wait are dropped.
